// File: rtl/chunked_adder.sv
// chunked_adder: in0+in1+cin over NCHUNK=nbits/cbits cycles (LSB chunk first); out_val rises NCHUNK cycles after accept.
// out/cout held while out_rdy=0, in_rdy low until the result is taken; CHUNKED_ADDER_OVF_EN adds the signed-overflow output ovf.
module chunked_adder #(
  parameter int nbits = 32,
  parameter int cbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [nbits-1:0] in0,
  input  logic [nbits-1:0] in1,
  input  logic             cin,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out,
  output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = nbits / cbits;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (nbits % cbits != 0) begin : g_bad_cfg
    $error("chunked_adder: nbits must be a multiple of cbits");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             carry;
  logic [nbits-1:0] a, b, res;
  logic             cout_r;
  logic [cbits:0]   sum;
  logic             accept;
  logic             last;

  assign in_rdy  = (state == IDLE) || ((state == DONE) && out_rdy);
  assign out_val = (state == DONE);
  assign accept  = in_val && in_rdy;
  assign out     = res;
  assign cout    = cout_r;
  assign last    = (count == CW'(NCHUNK - 1));

  always_comb begin
    sum = {1'b0, a[int'(count)*cbits +: cbits]}
        + {1'b0, b[int'(count)*cbits +: cbits]}
        + {{cbits{1'b0}}, carry};
  end

`ifdef CHUNKED_ADDER_OVF_EN
  logic ovf_r;
  assign ovf = ovf_r;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      carry  <= 1'b0;
      a      <= '0;
      b      <= '0;
      res    <= '0;
      cout_r <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          // From DONE, out_rdy gates in_rdy, so accept also completes the output handshake.
          if (accept) begin
            a     <= in0;
            b     <= in1;
            carry <= cin;
            count <= '0;
            state <= CALC;
          end else if (state == DONE && out_rdy) begin
            state <= IDLE;
          end
        end
        CALC: begin
          res[int'(count)*cbits +: cbits] <= sum[cbits-1:0];
          carry <= sum[cbits];
          count <= count + 1'b1;
          if (last) begin
            state  <= DONE;
            cout_r <= sum[cbits];
`ifdef CHUNKED_ADDER_OVF_EN
            // sum[cbits-1] is the msb of the full result on the final chunk.
            ovf_r  <= (a[nbits-1] == b[nbits-1]) && (sum[cbits-1] != a[nbits-1]);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: a 32/8 instance and an 8/8 instance share stimulus; a transaction-level model checks both every cycle.
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_val = 1'b0;
  logic        out_rdy = 1'b0;
  logic        cin = 1'b0;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;

  logic        in_rdy_a, out_val_a, cout_a;
  logic [31:0] out_a;
  logic        in_rdy_b, out_val_b, cout_b;
  logic [7:0]  out_b;
`ifdef CHUNKED_ADDER_OVF_EN
  logic        ovf_a, ovf_b;
`endif

  int tests = 0;
  int fails = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  chunked_adder #(.nbits(32), .cbits(8)) dut_a (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_a),
    .in0(in0), .in1(in1), .cin(cin), .out_val(out_val_a), .out_rdy(out_rdy),
    .out(out_a), .cout(cout_a)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf_a)
`endif
  );

  chunked_adder #(.nbits(8), .cbits(8)) dut_b (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_b),
    .in0(in0[7:0]), .in1(in1[7:0]), .cin(cin), .out_val(out_val_b), .out_rdy(out_rdy),
    .out(out_b), .cout(cout_b)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf_b)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- transaction-level model: index 0 = 32-bit/4 chunks, 1 = 8-bit/1 chunk ----
  int          cyc = 0;
  bit          pend[2];
  int          rdy_at[2];
  logic [31:0] e_out[2];
  bit          e_cout[2];
  bit          e_ovf[2];
  int          nch[2] = '{4, 1};
  int          wid[2] = '{32, 8};

  function automatic bit showing(input int i);
    return pend[i] && (cyc >= rdy_at[i]);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        pend[i] = 1'b0;
      end else begin
        bit sh, acc;
        logic [31:0] mask, am, bm;
        logic [32:0] s;
        sh  = showing(i);
        acc = in_val && (!pend[i] || (sh && out_rdy));
        if (sh && out_rdy) pend[i] = 1'b0;
        if (acc) begin
          mask      = (wid[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid[i]) - 32'd1);
          am        = in0 & mask;
          bm        = in1 & mask;
          s         = {1'b0, am} + {1'b0, bm} + {32'd0, cin};
          pend[i]   = 1'b1;
          rdy_at[i] = cyc + 1 + nch[i];
          e_out[i]  = s[31:0] & mask;
          e_cout[i] = s[wid[i]];
          e_ovf[i]  = (am[wid[i]-1] == bm[wid[i]-1]) && (s[wid[i]-1] != am[wid[i]-1]);
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (armed && !reset) begin
      check("a_out_val", out_val_a, showing(0));
      check("a_in_rdy", in_rdy_a, !pend[0] || (showing(0) && out_rdy));
      check("b_out_val", out_val_b, showing(1));
      check("b_in_rdy", in_rdy_b, !pend[1] || (showing(1) && out_rdy));
      if (showing(0)) begin
        check("a_out", out_a, e_out[0]);
        check("a_cout", cout_a, e_cout[0]);
`ifdef CHUNKED_ADDER_OVF_EN
        check("a_ovf", ovf_a, e_ovf[0]);
`endif
      end
      if (showing(1)) begin
        check("b_out", out_b, e_out[1][7:0]);
        check("b_cout", cout_b, e_cout[1]);
`ifdef CHUNKED_ADDER_OVF_EN
        check("b_ovf", ovf_b, e_ovf[1]);
`endif
      end
    end
  end

  // ---- directed + random stimulus; inputs change 2 time units after each rising edge ----
  task automatic cyc_step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_val_a(output int lat);
    lat = 0;
    while (!out_val_a && lat < 40) begin
      cyc_step();
      lat++;
    end
  endtask

  task automatic wait_idle();
    int n;
    in_val  = 1'b0;
    out_rdy = 1'b1;
    n = 0;
    while (!(in_rdy_a && !out_val_a && in_rdy_b && !out_val_b) && n < 40) begin
      cyc_step();
      n++;
    end
    check("wait_idle_timeout", n < 40, 1'b1);
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b, input logic c);
    in0 = a; in1 = b; cin = c; in_val = 1'b1;
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    cyc_step();
    cyc_step();
    reset = 1'b0;
    armed = 1'b1;
    check("rst_in_rdy", in_rdy_a, 1'b1);
    check("rst_out_val", out_val_a, 1'b0);
    check("rst_out", out_a, 32'h0);
    check("rst_cout", cout_a, 1'b0);
    check("rst_b_out", out_b, 8'h0);

    // carry ripple through every chunk
    out_rdy = 1'b1;
    offer(32'hFFFF_FFFF, 32'h0, 1'b1);
    cyc_step();
    in_val = 1'b0;
    check("ripple_b_calc", out_val_b, 1'b0);
    wait_val_a(lat);
    check("ripple_latency", lat, 4);
    check("ripple_out", out_a, 32'h0000_0000);
    check("ripple_cout", cout_a, 1'b1);
    wait_idle();

    // 8/8 build: single CALC cycle, signed overflow cases
    offer(32'h80, 32'h80, 1'b0);
    cyc_step();
    in_val = 1'b0;
    cyc_step();
    check("n1_val", out_val_b, 1'b1);
    check("n1_out_80_80", out_b, 8'h00);
    check("n1_cout_80_80", cout_b, 1'b1);
`ifdef CHUNKED_ADDER_OVF_EN
    check("n1_ovf_80_80", ovf_b, 1'b1);
`endif
    wait_idle();
    offer(32'h7F, 32'h01, 1'b0);
    cyc_step();
    in_val = 1'b0;
    cyc_step();
    check("n1_out_7f_01", out_b, 8'h80);
    check("n1_cout_7f_01", cout_b, 1'b0);
`ifdef CHUNKED_ADDER_OVF_EN
    check("n1_ovf_7f_01", ovf_b, 1'b1);
`endif
    wait_idle();

    // backpressure: result must hold, second operand set must wait
    out_rdy = 1'b0;
    offer(32'h1234_5678, 32'h1111_1111, 1'b0);
    cyc_step();
    offer(32'h5, 32'h7, 1'b0);
    wait_val_a(lat);
    check("bp_latency", lat, 4);
    check("bp_b_out", out_b, 8'h89);
    for (int k = 0; k < 5; k++) begin
      check("bp_out", out_a, 32'h2345_6789);
      check("bp_cout", cout_a, 1'b0);
      check("bp_in_rdy", in_rdy_a, 1'b0);
      check("bp_out_val", out_val_a, 1'b1);
      cyc_step();
    end
    out_rdy = 1'b1;
    cyc_step();
    in_val = 1'b0;
    wait_val_a(lat);
    check("bp_second_out", out_a, 32'hC);
    wait_idle();

    // back-to-back: second accept lands on the first output handshake
    offer(32'h1, 32'h2, 1'b0);
    cyc_step();
    offer(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_val_a(lat);
    check("b2b_lat1", lat, 4);
    check("b2b_out1", out_a, 32'h3);
    check("b2b_cout1", cout_a, 1'b0);
    cyc_step();
    in_val = 1'b0;
    check("b2b_gap_val", out_val_a, 1'b0);
    wait_val_a(lat);
    check("b2b_lat2", lat, 4);
    check("b2b_out2", out_a, 32'h0);
    check("b2b_cout2", cout_a, 1'b1);
`ifdef CHUNKED_ADDER_OVF_EN
    check("b2b_ovf2", ovf_a, 1'b1);
`endif
    wait_idle();

    // reset after two CALC cycles drops the transaction
    offer(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    cyc_step();
    in_val = 1'b0;
    cyc_step();
    cyc_step();
    reset = 1'b1;
    cyc_step();
    reset = 1'b0;
    check("mid_rst_in_rdy", in_rdy_a, 1'b1);
    for (int k = 0; k < 6; k++) begin
      check("mid_rst_no_val", out_val_a, 1'b0);
      cyc_step();
    end
    offer(32'h0F0F_0F0F, 32'h0101_0101, 1'b1);
    cyc_step();
    in_val = 1'b0;
    wait_val_a(lat);
    check("post_rst_out", out_a, 32'h1010_1011);
    wait_idle();

    // random traffic with random handshakes and occasional reset
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] v[2];
      for (int j = 0; j < 2; j++) begin
        case ($urandom_range(0, 5))
          0: v[j] = 32'hFFFF_FFFF;
          1: v[j] = 32'h0;
          2: v[j] = 32'h8000_0000;
          3: v[j] = 32'h7FFF_FFFF;
          default: v[j] = $urandom;
        endcase
      end
      in0     = v[0];
      in1     = v[1];
      cin     = 1'($urandom_range(0, 1));
      in_val  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 199) == 0);
      cyc_step();
    end
    reset = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
